uc_renderiza_canais: RTL and testbench
======================================

Name: uc_renderiza_canais

Overview:
Multi-channel frame-tick controller for the render path; successor to the single-channel render control unit.
- Each of N_CANAIS channels owns an internal frame counter, a programmable period, per-channel pause and single-step.
- Emits a one-cycle tick per frame, so multiple layers can refresh at independent rates: ship/asteroid layer, HUD, blink effects.
- Sits between the top control unit (pause, step, period programming) and the render datapath (consumes tick).

Parameters:
N_CANAIS, 2, number of independent channels (1..8)
LARGURA, 20, width of each channel's frame counter and period
PERIODO_PADRAO, 833333, period loaded at reset into every channel (60 Hz at 50 MHz)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset)
pausar_global  input  1  pauses all channels while 1
pausar  input  N_CANAIS  per-channel pause, level
passo  input  N_CANAIS  per-channel single-step request, sampled only while that channel is PAUSADO
carregar_periodo  input  1  one-cycle strobe; loads periodo into all channels' period registers
periodo  input  N_CANAIS*LARGURA  new periods, channel i at bits [i*LARGURA +: LARGURA]
tick  output  N_CANAIS  one-cycle frame pulse per channel
pausado_o  output  N_CANAIS  1 while channel is in PAUSADO or PASSO
quadros  output  N_CANAIS*16  per-channel frame count; feature-dependent, see Optional Feature
db_estado  output  N_CANAIS*4  per-channel state code, channel i at bits [i*4 +: 4]

Behaviour:
Reset (reset=0, async):
- All channels go to INICIAL; counters cleared; period registers = PERIODO_PADRAO.
- tick=0, pausado_o=0, quadros=0.

Pause condition per channel: p_i = pausar_global | pausar[i].

Per-channel Moore FSM; codes appear on db_estado:
- INICIAL (0): counter cleared -> ZERA.
- ZERA (1): counter cleared; p_i -> PAUSADO, else -> CONTA.
- CONTA (2):
  - Counter increments by 1 each cycle.
  - Terminal when cnt >= P_i-1, where P_i is the active period; P_i=0 is treated as 1.
  - On a terminal cycle: tick[i]=1 in that same cycle and counter wraps to 0; the FSM stays in CONTA (no dead cycle).
  - The first frame after ZERA is exactly P_i cycles; steady-state ticks are exactly P_i cycles apart.
  - Transition priority: p_i -> PAUSADO (no tick that cycle even if terminal) > carregar_periodo -> ZERA > stay.
- PAUSADO (3): counter holds; tick=0.
  - p_i=0 -> ZERA.
  - p_i=1 and passo[i]=1 -> PASSO.
  - else stay.
- PASSO (4): tick[i]=1 for exactly one cycle; counter unchanged -> PAUSADO regardless of inputs.
  - passo held high produces one tick every 2 cycles.
- ERRO (F): any unused encoding -> ERRO. Sticky until reset; tick=0; counter held.

Period registers:
- Written on carregar_periodo in any state.
- New value is used from the next cycle.
- A channel in CONTA restarts through ZERA, so the first frame with the new period is complete.
- Simultaneous carregar_periodo and a terminal cycle in CONTA: tick is still emitted; the FSM goes to ZERA.

Channels are fully independent except for the shared pausar_global and carregar_periodo.

Optional Feature:
UC_RENDERIZA_CONTA_FRAMES_EN
- Defined: each channel keeps a 16-bit frame counter on quadros, incremented on every tick[i] including PASSO ticks. It wraps 0xFFFF -> 0, is cleared only by reset, and is unaffected by pause or period load.
- Not defined: quadros is tied to 0 and no counter registers are synthesised.

Test Plan:
- Bench config: N_CANAIS=2, LARGURA=8; load periodo = {8'd6, 8'd4} right after reset release -> tick[0] every 4 cycles, tick[1] every 6 cycles; first tick[0] 4 cycles after CONTA entry; coincident ticks every 12 cycles.
- pausar[0]=1 for 10 cycles mid-frame -> tick[0]=0 and db_estado[3:0]=3 throughout; channel 1 unaffected. After release: ZERA for 1 cycle, then the next tick[0] exactly 4 cycles later.
- Pausing: while pausar_global=1, pulse passo=2'b11 for 1 cycle -> one tick on both channels in the next cycle (PASSO, code 4), then PAUSADO. Holding passo[0] for 6 cycles -> 3 ticks.
- Set periodo channel 0 = 0 -> tick[0] every cycle. Assert carregar_periodo on a terminal cycle -> tick asserted that cycle, then ZERA, then the new period applies.
- Drive reset=0 asynchronously mid-CONTA -> tick=0 and db_estado=0 immediately. After release, period registers are 833333 (default LARGURA) and the FSM passes INICIAL -> ZERA -> CONTA.
- With UC_RENDERIZA_CONTA_FRAMES_EN: 5 ticks on channel 1 -> quadros[31:16]=5; forcing the count to 0xFFFF plus one tick -> 0. Without the macro -> quadros=0 always.

Source files
------------

// File: rtl/uc_renderiza_canais.sv
// Multi-channel frame-tick controller: N_CANAIS independent frame counters with pause, single-step and period load.
// Optional per-channel 16-bit frame count on quadros enabled by defining UC_RENDERIZA_CONTA_FRAMES_EN.
module uc_renderiza_canais #(
    parameter int N_CANAIS       = 2,
    parameter int LARGURA        = 20,
    parameter int PERIODO_PADRAO = 833333
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          pausar_global,
    input  logic [N_CANAIS-1:0]           pausar,
    input  logic [N_CANAIS-1:0]           passo,
    input  logic                          carregar_periodo,
    input  logic [N_CANAIS*LARGURA-1:0]   periodo,
    output logic [N_CANAIS-1:0]           tick,
    output logic [N_CANAIS-1:0]           pausado_o,
    output logic [N_CANAIS*16-1:0]        quadros,
    output logic [N_CANAIS*4-1:0]         db_estado
);

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        ZERA    = 4'h1,
        CONTA   = 4'h2,
        PAUSADO = 4'h3,
        PASSO   = 4'h4,
        ERRO    = 4'hF
    } estado_t;

    estado_t              estado_q [N_CANAIS];
    estado_t              estado_d [N_CANAIS];
    logic [LARGURA-1:0]   cnt_q    [N_CANAIS];
    logic [LARGURA-1:0]   cnt_d    [N_CANAIS];
    logic [LARGURA-1:0]   per_q    [N_CANAIS];
    logic [LARGURA-1:0]   per_d    [N_CANAIS];
    logic [N_CANAIS-1:0]  pausa_c;
    logic [N_CANAIS-1:0]  term_c;
    logic [N_CANAIS-1:0]  tick_c;

    // A zero period behaves as one, so every CONTA cycle is terminal.
    always_comb begin
        pausa_c = '0;
        term_c  = '0;
        for (int i = 0; i < N_CANAIS; i++) begin
            pausa_c[i] = pausar_global | pausar[i];
            if (per_q[i] == '0) begin
                term_c[i] = 1'b1;
            end else begin
                term_c[i] = (cnt_q[i] >= (per_q[i] - LARGURA'(1)));
            end
        end
    end

    always_comb begin
        tick_c = '0;
        for (int i = 0; i < N_CANAIS; i++) begin
            estado_d[i] = estado_q[i];
            cnt_d[i]    = cnt_q[i];
            per_d[i]    = carregar_periodo ? periodo[i*LARGURA +: LARGURA] : per_q[i];
            case (estado_q[i])
                INICIAL: begin
                    cnt_d[i]    = '0;
                    estado_d[i] = ZERA;
                end
                ZERA: begin
                    cnt_d[i]    = '0;
                    estado_d[i] = pausa_c[i] ? PAUSADO : CONTA;
                end
                CONTA: begin
                    // Pause wins over a terminal cycle; a period load still lets the tick out.
                    if (pausa_c[i]) begin
                        estado_d[i] = PAUSADO;
                    end else begin
                        tick_c[i] = term_c[i];
                        cnt_d[i]  = term_c[i] ? '0 : cnt_q[i] + LARGURA'(1);
                        if (carregar_periodo) begin
                            estado_d[i] = ZERA;
                        end
                    end
                end
                PAUSADO: begin
                    if (!pausa_c[i]) begin
                        estado_d[i] = ZERA;
                    end else if (passo[i]) begin
                        estado_d[i] = PASSO;
                    end
                end
                PASSO: begin
                    tick_c[i]   = 1'b1;
                    estado_d[i] = PAUSADO;
                end
                ERRO: begin
                    estado_d[i] = ERRO;
                end
                default: begin
                    estado_d[i] = ERRO;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CANAIS; i++) begin
                estado_q[i] <= INICIAL;
                cnt_q[i]    <= '0;
                per_q[i]    <= LARGURA'(PERIODO_PADRAO);
            end
        end else begin
            for (int i = 0; i < N_CANAIS; i++) begin
                estado_q[i] <= estado_d[i];
                cnt_q[i]    <= cnt_d[i];
                per_q[i]    <= per_d[i];
            end
        end
    end

    always_comb begin
        db_estado = '0;
        pausado_o = '0;
        for (int i = 0; i < N_CANAIS; i++) begin
            db_estado[i*4 +: 4] = estado_q[i];
            pausado_o[i]        = (estado_q[i] == PAUSADO) || (estado_q[i] == PASSO);
        end
    end

    assign tick = tick_c;

`ifdef UC_RENDERIZA_CONTA_FRAMES_EN
    logic [15:0] quadros_q [N_CANAIS];
    logic [15:0] quadros_d [N_CANAIS];

    // Free-running frame count; wraps naturally at 16 bits.
    always_comb begin
        for (int i = 0; i < N_CANAIS; i++) begin
            quadros_d[i] = quadros_q[i] + {15'd0, tick_c[i]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CANAIS; i++) begin
                quadros_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CANAIS; i++) begin
                quadros_q[i] <= quadros_d[i];
            end
        end
    end

    always_comb begin
        quadros = '0;
        for (int i = 0; i < N_CANAIS; i++) begin
            quadros[i*16 +: 16] = quadros_q[i];
        end
    end
`else
    assign quadros = '0;
`endif

endmodule

// File: tb/tb_uc_renderiza_canais.sv
// Bench for uc_renderiza_canais: driver pushes per-cycle expected outputs from a countdown model, monitor pops and compares.
module tb_uc_renderiza_canais;
    localparam int N  = 2;
    localparam int L  = 8;
    localparam int PP = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             pausar_global = 1'b0;
    logic [N-1:0]     pausar = '0;
    logic [N-1:0]     passo = '0;
    logic             carregar_periodo = 1'b0;
    logic [N*L-1:0]   periodo = '0;
    logic [N-1:0]     tick;
    logic [N-1:0]     pausado_o;
    logic [N*16-1:0]  quadros;
    logic [N*4-1:0]   db_estado;

    always #5 clock = ~clock;

    uc_renderiza_canais #(.N_CANAIS(N), .LARGURA(L), .PERIODO_PADRAO(PP)) dut (
        .clock(clock), .reset(reset), .pausar_global(pausar_global), .pausar(pausar),
        .passo(passo), .carregar_periodo(carregar_periodo), .periodo(periodo),
        .tick(tick), .pausado_o(pausado_o), .quadros(quadros), .db_estado(db_estado)
    );

    logic [43:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Model: mode per channel (spec codes), frames-remaining countdown, period, frame count.
    int          m_mode [N];
    int          m_rem  [N];
    int          m_per  [N];
    logic [15:0] m_fr   [N];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_mode[c] = 0;
            m_rem[c]  = 0;
            m_per[c]  = PP;
            m_fr[c]   = 16'd0;
        end
    endtask

    task automatic model_step(output logic [43:0] e);
        logic [7:0]  db;
        logic [1:0]  pz;
        logic [1:0]  tk;
        logic [31:0] qd;
        int nm, eff, p, t;
        db = '0; pz = '0; tk = '0; qd = '0;
        if (!reset) begin
            model_reset();
            e = '0;
            return;
        end
        for (int c = 0; c < N; c++) begin
            p  = (pausar_global | pausar[c]) ? 1 : 0;
            nm = m_mode[c];
            t  = 0;
            db[c*4 +: 4] = 4'(m_mode[c]);
            pz[c] = (m_mode[c] == 3 || m_mode[c] == 4);
`ifdef UC_RENDERIZA_CONTA_FRAMES_EN
            qd[c*16 +: 16] = m_fr[c];
`endif
            case (m_mode[c])
                0: nm = 1;
                1: nm = p ? 3 : 2;
                2: begin
                    if (p) nm = 3;
                    else begin
                        t  = (m_rem[c] == 1) ? 1 : 0;
                        nm = carregar_periodo ? 1 : 2;
                    end
                end
                3: nm = !p ? 1 : (passo[c] ? 4 : 3);
                4: begin t = 1; nm = 3; end
                default: nm = m_mode[c];
            endcase
            if (carregar_periodo) m_per[c] = int'(periodo[c*L +: L]);
            eff = (m_per[c] == 0) ? 1 : m_per[c];
            if (m_mode[c] == 1 && nm == 2) m_rem[c] = eff;
            else if (m_mode[c] == 2 && nm == 2) m_rem[c] = t ? eff : m_rem[c] - 1;
            tk[c] = (t != 0);
            if (t != 0) m_fr[c] = m_fr[c] + 16'd1;
            m_mode[c] = nm;
        end
        e = {qd, db, pz, tk};
    endtask

    task automatic drive(input logic rst, input logic pg, input logic [1:0] pa,
                         input logic [1:0] ps, input logic car, input logic [15:0] pin,
                         input bit async_drop);
        logic [43:0] e;
        @(posedge clock);
        #1;
        pausar_global    = pg;
        pausar           = pa;
        passo            = ps;
        carregar_periodo = car;
        periodo          = pin;
        if (async_drop) begin
            #2;
            reset = 1'b0;
        end else begin
            reset = rst;
        end
        model_step(e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0);
    endtask

    logic [43:0] mon_exp;
    logic [43:0] mon_act;
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {quadros, db_estado, pausado_o, tick};
                n_cmp++;
                if (mon_act !== mon_exp) begin
                    n_err++;
                    $display("FAIL outputs t=%0t {quadros,db_estado,pausado_o,tick} got=%h exp=%h",
                             $time, mon_act, mon_exp);
                end
            end
        end
    end

    logic       r_pg;
    logic [1:0] r_pa;
    int         guard;
    initial begin
        model_reset();
        repeat (3) drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0);
        // Load {6,4} right after reset release.
        drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, {8'd6, 8'd4}, 1'b0);
        idle(30);
        // Channel 0 paused mid-frame.
        repeat (10) drive(1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 16'h0, 1'b0);
        idle(20);
        // Global pause, single step on both, then held step on channel 0.
        repeat (3) drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 1'b1, 2'b00, 2'b11, 1'b0, 16'h0, 1'b0);
        repeat (3) drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0);
        repeat (6) drive(1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 16'h0, 1'b0);
        repeat (2) drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0);
        idle(15);
        // Zero period on channel 0.
        drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, {8'd6, 8'd0}, 1'b0);
        idle(12);
        drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, {8'd6, 8'd4}, 1'b0);
        // Load on a terminal cycle of channel 0.
        guard = 0;
        while (!(m_mode[0] == 2 && m_rem[0] == 1) && guard < 20) begin
            idle(1);
            guard++;
        end
        drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, {8'd3, 8'd2}, 1'b0);
        idle(15);
        // Asynchronous reset in the middle of counting.
        drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 16'h0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0);
        idle(20);
        // Randomized traffic.
        r_pg = 1'b0;
        r_pa = 2'b00;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 29) == 0) r_pg = ~r_pg;
            if ($urandom_range(0, 11) == 0) r_pa[0] = ~r_pa[0];
            if ($urandom_range(0, 11) == 0) r_pa[1] = ~r_pa[1];
            drive(1'b1, r_pg, r_pa, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 24) == 0),
                  {8'($urandom_range(0, 9)), 8'($urandom_range(0, 9))}, 1'b0);
        end
        idle(5);
        repeat (3) @(posedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
